// File: rtl/fifo_uart_tx.sv
// Drains a normal-mode byte FIFO onto an 8N1 UART line, LSB first; tx falls 3 cycles after a non-empty FIFO is seen.
// One rdreq per byte; enable only gates the start of a new byte, so a fetched byte is always sent in full.
module fifo_uart_tx #(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       empty,
  input  logic [7:0] q,
  output logic       rdreq,
  output logic       tx,
  output logic       busy,
  output logic       byte_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_LATCH = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  state_t      state;
  logic [15:0] baud_cnt;
  logic [7:0]  shift_reg;
  logic [2:0]  bit_idx;
  logic        bit_end;

  assign bit_end = (baud_cnt == BAUD_LAST);

  // Single-term decode of a registered state: no glitches on the FIFO read strobe.
  assign rdreq = (state == S_RD);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      baud_cnt  <= 16'd0;
      shift_reg <= 8'd0;
      bit_idx   <= 3'd0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      byte_done <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (enable && !empty) begin
            state <= S_RD;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end
        S_RD: begin
          busy  <= 1'b1;
          state <= S_LATCH;
        end
        S_LATCH: begin
          shift_reg <= q;
          baud_cnt  <= 16'd0;
          bit_idx   <= 3'd0;
          state     <= S_START;
        end
        S_START: begin
          tx <= 1'b0;
          if (bit_end) begin
            baud_cnt <= 16'd0;
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        S_DATA: begin
          tx <= shift_reg[0];
          if (bit_end) begin
            baud_cnt  <= 16'd0;
            shift_reg <= {1'b0, shift_reg[7:1]};
            bit_idx   <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        S_STOP: begin
          tx <= 1'b1;
          if (bit_end) begin
            baud_cnt  <= 16'd0;
            byte_done <= 1'b1;
            state     <= S_IDLE;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench: a queue models the FIFO, frames are sampled every cycle and compared to hand-built bit patterns.
module tb_fifo_uart_tx;

  logic       clk;
  logic       reset_n;
  logic       enable, empty;
  logic [7:0] q;
  logic       rdreq, tx, busy, byte_done;
  logic       enable2, empty2;
  logic [7:0] q2;
  logic       rdreq2, tx2, busy2, byte_done2;

  int n_cmp = 0;
  int n_err = 0;
  int rd_cnt = 0;
  int bd_cnt = 0;
  int busy_cnt = 0;
  logic [7:0] fq[$];

  fifo_uart_tx #(.BAUD_DIV(4)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .empty(empty), .q(q),
    .rdreq(rdreq), .tx(tx), .busy(busy), .byte_done(byte_done)
  );

  fifo_uart_tx #(.BAUD_DIV(434)) dut434 (
    .clk(clk), .reset_n(reset_n), .enable(enable2), .empty(empty2), .q(q2),
    .rdreq(rdreq2), .tx(tx2), .busy(busy2), .byte_done(byte_done2)
  );

  always #5 clk = ~clk;

  // FIFO model: data appears after the rdreq cycle has been seen.
  always @(negedge clk) begin
    if (rdreq) begin
      if (fq.size() > 0) q = fq.pop_front();
      empty = (fq.size() == 0);
      rd_cnt++;
    end
    if (byte_done) bd_cnt++;
    if (busy) busy_cnt++;
    if (rdreq2) empty2 = 1'b1;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: observed no completion, expected bench to finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    empty = 1'b0;
  endtask

  task automatic clear_counts();
    rd_cnt = 0;
    bd_cnt = 0;
    busy_cnt = 0;
  endtask

  function automatic logic [39:0] frame_bits(input logic [7:0] b);
    logic [9:0]  lv;
    logic [39:0] r;
    lv = {1'b1, b, 1'b0};
    for (int i = 0; i < 40; i++) r[i] = lv[i / 4];
    return r;
  endfunction

  // Waits for the start bit, then samples tx/byte_done for the 40 cycles of the frame.
  // t returns the number of cycles polled before the start bit was seen.
  task automatic rx_frame(input logic [7:0] exp, input string tag, output int t, input int drop_at);
    logic [39:0] s, bd;
    t = 0;
    while (tx !== 1'b0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_start"}, 64'(t < 300), 64'd1);
    if (t < 300) begin
      for (int i = 0; i < 40; i++) begin
        s[i]  = tx;
        bd[i] = byte_done;
        if (i == drop_at) enable = 1'b0;
        @(negedge clk);
      end
      check({tag, "_bits"}, 64'(s), 64'(frame_bits(exp)));
      check({tag, "_done"}, 64'(bd), 64'(40'h1 << 39));
    end
  endtask

  initial begin
    logic [7:0] burst[34];
    int t, bad, cnt;
    logic prev;

    clk = 0; reset_n = 0; enable = 0; empty = 1; q = 8'h00;
    enable2 = 0; empty2 = 1; q2 = 8'h55;
    repeat (3) @(negedge clk);
    check("rst_tx", 64'(tx), 64'd1);
    check("rst_rdreq", 64'(rdreq), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_byte_done", 64'(byte_done), 64'd0);
    check("rst_tx434", 64'(tx2), 64'd1);
    reset_n = 1;
    @(negedge clk);

    // Single byte 0xA5
    clear_counts();
    push(8'hA5);
    enable = 1;
    rx_frame(8'hA5, "a5", t, -1);
    check("a5_latency", 64'(t), 64'd4);
    repeat (10) @(negedge clk);
    check("a5_rdreq_cnt", 64'(rd_cnt), 64'd1);
    check("a5_done_cnt", 64'(bd_cnt), 64'd1);
    check("a5_busy_cycles", 64'(busy_cnt), 64'd43);

    // 34-byte polling burst, terminators last
    clear_counts();
    for (int i = 0; i < 32; i++) burst[i] = 8'(i * 37 + 5);
    burst[32] = 8'h0D;
    burst[33] = 8'h0A;
    for (int i = 0; i < 34; i++) push(burst[i]);
    for (int k = 0; k < 34; k++) begin
      rx_frame(burst[k], "burst", t, -1);
      if (k == 0) check("burst_latency", 64'(t), 64'd4);
      else        check("burst_gap", 64'(t), 64'd3);
    end
    repeat (10) @(negedge clk);
    check("burst_rdreq_cnt", 64'(rd_cnt), 64'd34);
    check("burst_done_cnt", 64'(bd_cnt), 64'd34);

    // Empty FIFO with enable high
    clear_counts();
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (rdreq !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("idle_bad_cycles", 64'(bad), 64'd0);
    check("idle_rdreq_cnt", 64'(rd_cnt), 64'd0);

    // enable dropped inside the data bits of 0x3C
    clear_counts();
    push(8'h3C);
    push(8'h77);
    rx_frame(8'h3C, "en_drop", t, 10);
    repeat (20) @(negedge clk);
    check("en_drop_rdreq_cnt", 64'(rd_cnt), 64'd1);
    check("en_drop_busy", 64'(busy), 64'd0);
    check("en_drop_tx", 64'(tx), 64'd1);
    enable = 1;
    rx_frame(8'h77, "en_resume", t, -1);
    check("en_resume_latency", 64'(t), 64'd4);

    // Async reset in the middle of a data bit
    clear_counts();
    push(8'h96);
    push(8'h5A);
    t = 0;
    while (tx !== 1'b0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("mid_rst_start", 64'(t < 300), 64'd1);
    repeat (10) @(negedge clk);
    reset_n = 0;
    #1;
    check("mid_rst_tx", 64'(tx), 64'd1);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_rdreq", 64'(rdreq), 64'd0);
    @(negedge clk);
    reset_n = 1;
    rx_frame(8'h5A, "post_rst", t, -1);
    check("post_rst_latency", 64'(t), 64'd4);
    check("post_rst_rdreq_cnt", 64'(rd_cnt), 64'd2);

    // BAUD_DIV=434, byte 0x55: every boundary toggles tx
    enable2 = 1;
    empty2 = 0;
    cnt = 0;
    while (tx2 !== 1'b0 && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    check("b434_start", 64'(cnt < 2000), 64'd1);
    for (int j = 0; j < 9; j++) begin
      prev = tx2;
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (tx2 === prev && cnt < 1000);
      check("b434_period", 64'(cnt), 64'd434);
    end
    // byte_done marks the last cycle of the 434-cycle stop bit
    cnt = 0;
    while (byte_done2 !== 1'b1 && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    check("b434_stop", 64'(cnt), 64'd433);
    check("b434_stop_level", 64'(tx2), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
